// File: rtl/scc_pkg.sv
// scc_pkg: shared state encoding and bus widths for the run controller/checker.
package scc_pkg;
    typedef enum logic [2:0] {S_HOLD, S_RUN, S_STOP, S_READ, S_CMP, S_DONE} scc_state_e;
    localparam int SCC_MEM_RD_LAT = 1;
    localparam int SCC_ADDR_W     = 32;
    localparam int SCC_DATA_W     = 32;
endpackage

// File: rtl/scc_sat_counter.sv
// scc_sat_counter: up-counter that sticks at all-ones instead of wrapping.
module scc_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk) begin
        if (rst || clr) r_count <= '0;
        else if (inc && r_count != '1) r_count <= r_count + 1'b1;
    end
    assign count = r_count;
endmodule

// File: rtl/scc_run_checker.sv
// scc_run_checker: sequences core reset/enable, times the run, then reads back
// a list of memory locations and reduces everything to a done/pass verdict.
module scc_run_checker
    import scc_pkg::*;
#(
    parameter int NUM_CHECKS   = 2,
    parameter int TIMEOUT      = 100000,
    parameter int RESET_CYCLES = 3,
    parameter int IDX_W        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           halt_f,
    input  logic [1:0]                     err_bits,
    input  logic [SCC_ADDR_W*NUM_CHECKS-1:0] chk_addr,
    input  logic [SCC_DATA_W*NUM_CHECKS-1:0] chk_value,
    output logic                           core_rst,
    output logic                           clk_en,
    output logic                           mem_rd_en,
    output logic [SCC_ADDR_W-1:0]          mem_rd_addr,
    input  logic [SCC_DATA_W-1:0]          mem_rd_data,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [IDX_W:0]                 fail_count,
    output logic [IDX_W-1:0]               fail_idx,
    output logic [SCC_DATA_W-1:0]          fail_value,
    output logic [31:0]                    cycle_count
);
    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

    scc_state_e             r_state, w_next;
    logic [HOLD_W-1:0]      w_hold_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [1:0]             r_err;
    logic                   r_timeout;
    logic [IDX_W:0]         r_fail_count;
    logic [IDX_W-1:0]       r_fail_idx;
    logic [SCC_DATA_W-1:0]  r_fail_value;
    logic                   w_in_hold, w_in_run, w_hold_last, w_to_hit, w_last_chk, w_mismatch;
    logic [SCC_DATA_W-1:0]  w_exp;
    logic [SCC_ADDR_W-1:0]  w_addr;

    assign w_in_hold   = r_state == S_HOLD;
    assign w_in_run    = r_state == S_RUN;
    assign w_hold_last = w_hold_cnt == HOLD_W'(RESET_CYCLES - 1);
    assign w_to_hit    = cycle_count == 32'(TIMEOUT - 1);
    assign w_last_chk  = r_idx == IDX_W'(NUM_CHECKS - 1);
    assign w_exp       = chk_value[r_idx*SCC_DATA_W +: SCC_DATA_W];
    assign w_addr      = chk_addr[r_idx*SCC_ADDR_W +: SCC_ADDR_W];
    // Read data arrives in CMP, one cycle after the READ strobe.
    assign w_mismatch  = mem_rd_data != w_exp;

    scc_sat_counter #(.W(HOLD_W)) u_hold (
        .clk(clk), .rst(rst), .inc(w_in_hold), .clr(!w_in_hold), .count(w_hold_cnt)
    );

    scc_sat_counter #(.W(32)) u_cycles (
        .clk(clk), .rst(rst), .inc(w_in_run), .clr(1'b0), .count(cycle_count)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_HOLD;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = S_HOLD;
        case (r_state)
            S_HOLD: w_next = w_hold_last ? S_RUN : S_HOLD;
            S_RUN:  w_next = (halt_f || w_to_hit) ? S_STOP : S_RUN;
            S_STOP: w_next = S_READ;
            S_READ: w_next = S_CMP;
            S_CMP:  w_next = w_last_chk ? S_DONE : S_READ;
            S_DONE: w_next = S_DONE;
            default: w_next = S_HOLD;
        endcase
    end

    always_comb begin
        core_rst    = w_in_hold;
        clk_en      = w_in_run;
        mem_rd_en   = r_state == S_READ;
        mem_rd_addr = mem_rd_en ? w_addr : '0;
        done        = r_state == S_DONE;
        pass        = done && r_fail_count == '0 && !r_timeout && r_err == 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_err        <= '0;
            r_timeout    <= 1'b0;
            r_fail_count <= '0;
            r_fail_idx   <= '0;
            r_fail_value <= '0;
        end else begin
            // A halt in the same cycle as the timeout is treated as a clean stop.
            if (w_in_run && w_to_hit && !halt_f) r_timeout <= 1'b1;
            if (r_state == S_STOP) begin
                r_err <= err_bits;
                r_idx <= '0;
            end
            if (r_state == S_CMP) begin
                if (!w_last_chk) r_idx <= r_idx + 1'b1;
                if (w_mismatch) begin
                    r_fail_count <= r_fail_count + 1'b1;
                    if (r_fail_count == '0) begin
                        r_fail_idx   <= r_idx;
                        r_fail_value <= mem_rd_data;
                    end
                end
            end
        end
    end

    assign timeout    = r_timeout;
    assign fail_count = r_fail_count;
    assign fail_idx   = r_fail_idx;
    assign fail_value = r_fail_value;
endmodule

// File: tb/tb_scc_run_checker.sv
// tb_scc_run_checker: two checker instances (default and TIMEOUT=20) on shared stimulus;
// expected verdicts are queued when a run is launched and compared once done rises.
module tb_scc_run_checker;
    localparam int NC = 2;

    typedef struct {
        logic [31:0] cyc;
        logic        to;
        logic        ps;
        logic [1:0]  fc;
        logic        fi;
        logic [31:0] fv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_f = 1'b0;
    logic [1:0]  err_bits = 2'b00;
    logic [63:0] chk_addr  = {32'h0000_0408, 32'h0000_0404};
    logic [63:0] chk_value = {32'h0000_0039, 32'h0000_0040};
    logic [31:0] m0 = 32'h40, m1 = 32'h39;
    bit          use_to = 1'b0;
    int          n_chk = 0, n_bad = 0;
    exp_t        sb[$];

    logic        a_core_rst, a_clk_en, a_rd_en, a_done, a_pass, a_timeout, a_fail_idx;
    logic [31:0] a_rd_addr, a_rd_data, a_fail_value, a_cycle_count;
    logic [1:0]  a_fail_count;
    logic        b_core_rst, b_clk_en, b_rd_en, b_done, b_pass, b_timeout, b_fail_idx;
    logic [31:0] b_rd_addr, b_rd_data, b_fail_value, b_cycle_count;
    logic [1:0]  b_fail_count;

    logic        o_core_rst, o_clk_en, o_rd_en, o_done, o_pass, o_timeout, o_fail_idx;
    logic [31:0] o_fail_value, o_cycle_count;
    logic [1:0]  o_fail_count;

    always #5 clk = ~clk;

    scc_run_checker #(.NUM_CHECKS(NC)) u_dut (
        .clk(clk), .rst(rst), .halt_f(halt_f), .err_bits(err_bits),
        .chk_addr(chk_addr), .chk_value(chk_value),
        .core_rst(a_core_rst), .clk_en(a_clk_en), .mem_rd_en(a_rd_en),
        .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
        .done(a_done), .pass(a_pass), .timeout(a_timeout),
        .fail_count(a_fail_count), .fail_idx(a_fail_idx),
        .fail_value(a_fail_value), .cycle_count(a_cycle_count)
    );

    scc_run_checker #(.NUM_CHECKS(NC), .TIMEOUT(20)) u_dut_to (
        .clk(clk), .rst(rst), .halt_f(halt_f), .err_bits(err_bits),
        .chk_addr(chk_addr), .chk_value(chk_value),
        .core_rst(b_core_rst), .clk_en(b_clk_en), .mem_rd_en(b_rd_en),
        .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
        .done(b_done), .pass(b_pass), .timeout(b_timeout),
        .fail_count(b_fail_count), .fail_idx(b_fail_idx),
        .fail_value(b_fail_value), .cycle_count(b_cycle_count)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        return addr == 32'h404 ? m0 : addr == 32'h408 ? m1 : 32'hBAD0_BAD0;
    endfunction

    always_ff @(posedge clk) begin
        a_rd_data <= a_rd_en ? mem_rd(a_rd_addr) : 32'h0;
        b_rd_data <= b_rd_en ? mem_rd(b_rd_addr) : 32'h0;
    end

    assign o_core_rst    = use_to ? b_core_rst    : a_core_rst;
    assign o_clk_en      = use_to ? b_clk_en      : a_clk_en;
    assign o_rd_en       = use_to ? b_rd_en       : a_rd_en;
    assign o_done        = use_to ? b_done        : a_done;
    assign o_pass        = use_to ? b_pass        : a_pass;
    assign o_timeout     = use_to ? b_timeout     : a_timeout;
    assign o_fail_idx    = use_to ? b_fail_idx    : a_fail_idx;
    assign o_fail_value  = use_to ? b_fail_value  : a_fail_value;
    assign o_cycle_count = use_to ? b_cycle_count : a_cycle_count;
    assign o_fail_count  = use_to ? b_fail_count  : a_fail_count;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_case(input bit to_dut, input int halt_at, input logic [1:0] eb,
                            input logic [31:0] v0, input logic [31:0] v1, input bit abort);
        exp_t e;
        int   lim, n, en_cyc, rd;
        bit   halted;
        lim = to_dut ? 20 : 100000;
        use_to = to_dut;
        m0 = v0;
        m1 = v1;
        err_bits = eb;
        halt_f = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_core_rst", o_core_rst, 1);
        chk("rst_clk_en", o_clk_en, 0);
        chk("rst_done", o_done, 0);
        chk("rst_cycles", o_cycle_count, 0);
        chk("rst_fail_count", o_fail_count, 0);
        if (!abort) begin
            halted = halt_at > 0 && halt_at <= lim;
            e.cyc = halted ? halt_at : lim;
            e.to  = !halted;
            e.fc  = 2'((v0 != 32'h40) + (v1 != 32'h39));
            e.fi  = v0 == 32'h40 && v1 != 32'h39;
            e.fv  = v0 != 32'h40 ? v0 : v1 != 32'h39 ? v1 : 32'h0;
            e.ps  = e.fc == 0 && !e.to && eb == 2'b00;
            sb.push_back(e);
        end
        rst = 1'b0;
        n = 0;
        while (!o_clk_en && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("hold_len", n, 3);
        chk("core_rst_run", o_core_rst, 0);
        en_cyc = 0;
        while (o_clk_en && en_cyc < 200) begin
            en_cyc++;
            halt_f = en_cyc == halt_at;
            @(negedge clk);
        end
        halt_f = 1'b0;
        if (abort) begin
            repeat (4) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("abort_done", o_done, 0);
            chk("abort_core_rst", o_core_rst, 1);
            chk("abort_cycles", o_cycle_count, 0);
            chk("abort_fail_count", o_fail_count, 0);
            return;
        end
        chk("run_len", en_cyc, halted ? halt_at : lim);
        n = 0;
        rd = 0;
        while (!o_done && n < 20) begin
            if (o_rd_en) rd++;
            @(negedge clk);
            n++;
        end
        chk("done_lat", n, 1 + 2 * NC);
        chk("rd_pulses", rd, NC);
        e = sb.pop_front();
        chk("cycle_count", o_cycle_count, e.cyc);
        chk("timeout", o_timeout, e.to);
        chk("pass", o_pass, e.ps);
        chk("fail_count", o_fail_count, e.fc);
        chk("fail_idx", o_fail_idx, e.fi);
        chk("fail_value", o_fail_value, e.fv);
        repeat (3) @(negedge clk);
        chk("done_sticky", o_done, 1);
        chk("pass_sticky", o_pass, e.ps);
        chk("rd_idle", o_rd_en, 0);
    endtask

    initial begin
        run_case(1'b0, 50, 2'b00, 32'h40, 32'h39, 1'b0);
        run_case(1'b0, 50, 2'b00, 32'h41, 32'h38, 1'b0);
        run_case(1'b0, 50, 2'b00, 32'h40, 32'h38, 1'b0);
        run_case(1'b1, 0,  2'b00, 32'h40, 32'h39, 1'b0);
        run_case(1'b1, 20, 2'b00, 32'h40, 32'h39, 1'b0);
        run_case(1'b1, 19, 2'b00, 32'h40, 32'h39, 1'b0);
        run_case(1'b0, 30, 2'b01, 32'h40, 32'h39, 1'b0);
        run_case(1'b0, 50, 2'b00, 32'h40, 32'h39, 1'b1);
        run_case(1'b0, 50, 2'b00, 32'h40, 32'h39, 1'b0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/scc_run_checker.md
# scc_run_checker

Synthesizable run controller and result checker that wraps the `scc_f25_top` core. It sequences core reset and clock enable, then counts executed cycles until the core halts or a timeout expires. After that it reads a parameterised list of data-memory locations through a read port and compares them against expected values. A single `done`/`pass` verdict replaces file-based post-run checking, so benches and FPGA builds use the same self-check.

## Interface
Parameters:
- `NUM_CHECKS`, 2: number of (address, expected value) pairs; must be ≥1.
- `TIMEOUT`, 100000: maximum RUN cycles before a forced stop.
- `RESET_CYCLES`, 3: cycles `core_rst` is held after `rst` releases; must be ≥1.
- `IDX_W`, `$clog2(NUM_CHECKS)` with a minimum of 1: width of check index.

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `halt_f` in 1: core halt flag.
- `err_bits` in 2: core error flags.
- `chk_addr` in 32*NUM_CHECKS: expected addresses, flattened; entry i is at bits [32i+31:32i].
- `chk_value` in 32*NUM_CHECKS: expected values, flattened the same way.
- `core_rst` out 1: reset to the core.
- `clk_en` out 1: enable to the core.
- `mem_rd_en` out 1: data-memory read strobe.
- `mem_rd_addr` out 32: read address.
- `mem_rd_data` in 32: read data, returned 1 cycle after the strobe.
- `done` out 1: verdict valid; sticky until `rst`.
- `pass` out 1: all checks matched, no timeout, `err_bits` was 0 at stop.
- `timeout` out 1: the stop was caused by TIMEOUT.
- `fail_count` out IDX_W+1: number of mismatches.
- `fail_idx` out IDX_W: index of the first mismatch.
- `fail_value` out 32: value read at the first mismatch.
- `cycle_count` out 32: RUN cycles executed; saturates at 0xFFFFFFFF.

## Operation
- **States:** HOLD → RUN → STOP → READ ⇄ CMP → DONE.
- **HOLD:**
  - Outputs: `core_rst`=1, `clk_en`=0.
  - A hold counter runs from 0 to RESET_CYCLES-1.
  - On the last count, go to RUN.
  - `halt_f` is ignored in this state.
- **RUN:**
  - Outputs: `core_rst`=0, `clk_en`=1.
  - `cycle_count` increments every cycle.
  - If `halt_f`=1: go to STOP.
  - Else if `cycle_count` == TIMEOUT-1 (that cycle's pre-increment value): go to STOP and set `timeout`.
  - If both conditions hold in the same cycle, halt wins and `timeout` stays 0.
- **STOP:**
  - `clk_en`=0.
  - Latch `err_bits` into an error register.
  - Reset the check index to 0.
  - Spend one settle cycle so the last store commits, then go to READ.
- **READ:** `mem_rd_en`=1, `mem_rd_addr`=`chk_addr[idx]`, then go to CMP.
- **CMP:**
  - Compare `mem_rd_data` with `chk_value[idx]`.
  - On mismatch, increment `fail_count`. On the first mismatch only, capture `fail_idx`=idx and `fail_value`=`mem_rd_data`.
  - If idx==NUM_CHECKS-1, go to DONE; else increment idx and go to READ.
- **DONE:**
  - `done`=1.
  - `pass` = (`fail_count`==0) & !`timeout` & (latched error bits==0).
  - Remains in DONE until `rst`.

## Timing
- **Reset values:**
  - `core_rst`=1.
  - Every other output is 0, including `clk_en`, `mem_rd_en`, `mem_rd_addr`, `done`, `pass`, `timeout`, `fail_*`, `cycle_count`.
- **`rst` asserted in any state:** the next state is HOLD and all registers clear. This covers `rst` mid-RUN and mid-check.
- **Core start:**
  - `clk_en` first rises RESET_CYCLES cycles after `rst` deasserts.
  - `core_rst` falls on the same edge that `clk_en` rises.
- **Halt response:**
  - `halt_f` high in RUN cycle N gives `clk_en`=0 from cycle N+1.
  - `cycle_count` then equals the number of RUN cycles, including cycle N.
- **Check latency:**
  - `done` rises 1 + 2*NUM_CHECKS cycles after the first non-RUN cycle.
  - Example: NUM_CHECKS=2 gives 5 cycles.
- **Read port:** `mem_rd_en` is a single-cycle pulse per check and is never asserted outside READ.
- **Output stability:** `fail_*` and `timeout` are stable once set, until `rst`.

## Structure
- Shared package `scc_pkg`:
  - State enum.
  - Constant `SCC_MEM_RD_LAT`=1.
  - Constant `SCC_ADDR_W`=32.
  - Constant `SCC_DATA_W`=32.
- One sub-module, `scc_sat_counter` (width param, `inc`, `clr`, `count` out, saturating). It is used for both the hold counter and `cycle_count`.
- Integration: instantiated beside `scc_f25_top`; the read port is shared with the data-memory debug port.

## Test plan
- **Pass case:** NUM_CHECKS=2, checks (0x404→0x40, 0x408→0x39); memory model holds those values; `halt_f` pulses at RUN cycle 50.
  - Required: `clk_en` high for exactly 50 cycles, `cycle_count`=50, `done` 5 cycles later, `pass`=1, `fail_count`=0.
- **Mismatch:** memory holds 0x404=0x41 and 0x408=0x38.
  - Required: `fail_count`=2, `fail_idx`=0, `fail_value`=0x41, `pass`=0.
- **Timeout:** TIMEOUT=20, `halt_f` never asserts, memory matches.
  - Required: `clk_en` deasserts after 20 RUN cycles, `timeout`=1, `cycle_count`=20, `pass`=0.
- **Simultaneous halt and timeout:** `halt_f` rises on RUN cycle 20 with TIMEOUT=20.
  - Required: `timeout`=0, `pass`=1.
- **Error flags:** `err_bits`=2'b01 at halt, memory matches.
  - Required: `pass`=0, `fail_count`=0.
- **Reset mid-operation:** `rst` asserted in CMP of check 1, then released.
  - Required: `done`=0, `core_rst`=1 for 3 cycles, full rerun gives an identical verdict.
